// File: rtl/hog_pkg.sv
// Shared HOG pipeline types and constants: debounce states and default widths/timings.
package hog_pkg;

  localparam int unsigned HOG_DATA_WIDTH            = 8;
  localparam int unsigned HOG_DEBOUNCE_CYCLES_10MHZ = 100000;
  localparam int unsigned PIXEL_COUNT_WIDTH         = 16;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head and occupancy counter.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         head_ptr;
  logic                  wr_en;
  logic                  rd_en;
  logic [LW-1:0]         level_next;

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  always_comb begin
    rd_en      = pop & ~empty;
    wr_en      = push & (~full | rd_en);
    level_next = level + LW'(wr_en) - LW'(rd_en);
    head_ptr   = rd_en ? rd_ptr + AW'(1) : rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // The next head bypasses the array when it is the slot being written right now.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      dout   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_next;
      empty <= (level_next == '0);
      full  <= (level_next == LW'(DEPTH));
      if (level_next != '0) begin
        dout <= (wr_en && (wr_ptr == head_ptr)) ? din : mem[head_ptr];
      end
    end
  end

endmodule

// File: rtl/pixel_input_stage.sv
// Key-press pixel source: synchronises and debounces KEY, pushes one switch sample per press into a FIFO.
module pixel_input_stage
  import hog_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = HOG_DATA_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = HOG_DEBOUNCE_CYCLES_10MHZ,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           key_n,
  input  logic [DATA_WIDTH-1:0]          switch_pixel,
  output logic [DATA_WIDTH-1:0]          pixel_out,
  output logic                           pixel_valid,
  input  logic                           pixel_ready,
  output logic                           overflow,
  output logic [PIXEL_COUNT_WIDTH-1:0]   pixel_count,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic                  key_meta;
  logic                  key_s;
  logic [DATA_WIDTH-1:0] sw_meta;
  logic [DATA_WIDTH-1:0] sw_s;

  deb_state_e            state;
  deb_state_e            state_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  push_c;
  logic                  push;

  logic                  pop;
  logic                  push_drop;
  logic                  fifo_empty;
  logic                  fifo_full;

  // Two-flop synchronisers; key idles released (high).
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
      sw_meta  <= '0;
      sw_s     <= '0;
    end else begin
      key_meta <= key_n;
      key_s    <= key_meta;
      sw_meta  <= switch_pixel;
      sw_s     <= sw_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= '0;
      push  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      push  <= push_c;
    end
  end

  // Debounce: a level must hold for DEBOUNCE_CYCLES before the press or release is accepted.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    push_c     = 1'b0;
    case (state)
      RELEASED: begin
        if (!key_s) begin
          state_next = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_next = RELEASED;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_next = PRESSED;
          push_c     = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_next = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_next = PRESSED;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_next = RELEASED;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = RELEASED;
      end
    endcase
  end

  assign pop         = pixel_valid & pixel_ready;
  assign push_drop   = push & fifo_full & ~pop;
  assign pixel_valid = ~fifo_empty;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (sw_s),
    .dout  (pixel_out),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  // Sticky drop flag and count of pushes the FIFO actually took.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow    <= 1'b0;
      pixel_count <= '0;
    end else begin
      if (push_drop) begin
        overflow <= 1'b1;
      end
      if (push && !push_drop) begin
        pixel_count <= pixel_count + PIXEL_COUNT_WIDTH'(1);
      end
    end
  end

endmodule
